// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uc_pkg
// Description : Shared definitions for the unit-clause path: literal space,
//               literal layout, arbiter state encoding and literal helpers.
//               Used by the queues, the engines and uc_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package uc_pkg;

  // Literal space. A literal is {neg, var}; var 0 is the null literal.
  localparam int UC_LENGTH = 512;
  localparam int LIT_W     = $clog2(UC_LENGTH);
  localparam int VAR_W     = LIT_W - 1;

  typedef struct packed {
    logic             neg;
    logic [VAR_W-1:0] vid;
  } uc_lit_t;

  // Arbiter state encoding.
  typedef enum logic [1:0] {
    UC_IDLE     = 2'd0,
    UC_CHECK    = 2'd1,
    UC_BCAST    = 2'd2,
    UC_CONFLICT = 2'd3
  } uc_state_e;

  // Build a literal from polarity and variable index.
  function automatic uc_lit_t uc_make_lit(input logic neg, input logic [VAR_W-1:0] vid);
    uc_lit_t l;
    l.neg = neg;
    l.vid = vid;
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uc_arbiter_if
// Description : Unit-clause queue and broadcast bundle between the engine
//               queues / engines and uc_arbiter.
// Ports       : ucq_empty  per-queue empty flag          (queues -> arbiter)
//               ucq_head   per-queue head literal        (queues -> arbiter)
//               ucq_pop    one-hot pop pulse             (arbiter -> queues)
//               bc_valid   broadcast literal valid       (arbiter -> engines)
//               bc_lit     broadcast literal             (arbiter -> engines)
//               bc_ready   per-engine accept             (engines -> arbiter)
// Revision    : 1.0  initial release
// ============================================================================
interface uc_arbiter_if #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = uc_pkg::LIT_W
) ();

  logic [NUM_ENG-1:0]            ucq_empty;
  logic [NUM_ENG-1:0][LIT_W-1:0] ucq_head;
  logic [NUM_ENG-1:0]            ucq_pop;
  logic                          bc_valid;
  logic [LIT_W-1:0]              bc_lit;
  logic [NUM_ENG-1:0]            bc_ready;

  // Arbiter side.
  modport master (
    input  ucq_empty,
    input  ucq_head,
    input  bc_ready,
    output ucq_pop,
    output bc_valid,
    output bc_lit
  );

  // Queue / engine side.
  modport slave (
    output ucq_empty,
    output ucq_head,
    output bc_ready,
    input  ucq_pop,
    input  bc_valid,
    input  bc_lit
  );

endinterface
`default_nettype wire

// File: rtl/uc_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Search starts at the pointer; on an
//               enabled grant the pointer moves to the index after the winner.
// Ports       : clk    clock
//               rst    asynchronous active-low reset (pointer -> 0)
//               req    request vector
//               en     commit the current grant (advance pointer)
//               grant  one-hot grant, zero when no request
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] gidx;
  logic             found;
  logic [PTR_W-1:0] idx_w;
  int               idx;

  // First requester at or after the pointer, wrapping at N.
  always_comb begin
    grant = '0;
    gidx  = ptr_q;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      idx_w = idx[PTR_W-1:0];
      if (!found && req[idx_w]) begin
        found        = 1'b1;
        grant[idx_w] = 1'b1;
        gidx         = idx_w;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && found) begin
      ptr_d = (gidx == PTR_W'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/uc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uc_arbiter
// Description : Pulls unit-clause literals from the engine queues in
//               round-robin order, checks them against the assignment table
//               and broadcasts new assignments to every engine. Opposite
//               polarity on an assigned variable raises a sticky conflict.
// Ports       : clk           clock
//               rst           asynchronous active-low reset
//               clr           synchronous solver restart
//               bus           queue/broadcast bundle (master modport)
//               conflict      sticky conflict flag
//               conflict_lit  literal that caused the conflict
//               busy          not idle
//               bc_cnt        saturating count of completed broadcasts
// Revision    : 1.0  initial release
// ============================================================================
module uc_arbiter
  import uc_pkg::*;
#(
  parameter int NUM_ENG   = 4,
  parameter int UC_LENGTH = uc_pkg::UC_LENGTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  uc_arbiter_if.master                 bus,
  output logic                         conflict,
  output logic [$clog2(UC_LENGTH)-1:0] conflict_lit,
  output logic                         busy,
  output logic [15:0]                  bc_cnt
);

  localparam int LIT_W    = $clog2(UC_LENGTH);
  localparam int VAR_W    = LIT_W - 1;
  localparam int NUM_VARS = UC_LENGTH / 2;

  localparam logic [1:0] ST_IDLE     = 2'(UC_IDLE);
  localparam logic [1:0] ST_CHECK    = 2'(UC_CHECK);
  localparam logic [1:0] ST_BCAST    = 2'(UC_BCAST);
  localparam logic [1:0] ST_CONFLICT = 2'(UC_CONFLICT);

  logic [1:0]          state_q,        state_d;
  logic [LIT_W-1:0]    lit_q,          lit_d;
  logic [NUM_ENG-1:0]  mask_q,         mask_d;
  logic                conflict_q,     conflict_d;
  logic [LIT_W-1:0]    conflict_lit_q, conflict_lit_d;
  logic [15:0]         cnt_q,          cnt_d;
  logic [NUM_VARS-1:0] assigned_q,     assigned_d;
  logic [NUM_VARS-1:0] value_q,        value_d;

  logic [NUM_ENG-1:0]  req;
  logic [NUM_ENG-1:0]  grant;
  logic                pop_en;
  logic [LIT_W-1:0]    grant_lit;
  logic [VAR_W-1:0]    lit_var;
  logic                lit_neg;

  assign req     = ~bus.ucq_empty;
  assign lit_var = lit_q[VAR_W-1:0];
  assign lit_neg = lit_q[LIT_W-1];

  rr_arbiter #(
    .N (NUM_ENG)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (pop_en),
    .grant (grant)
  );

  // Head literal of the granted queue (grant is one-hot or zero).
  always_comb begin
    grant_lit = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (grant[i]) grant_lit = grant_lit | bus.ucq_head[i];
    end
  end

  always_comb begin
    state_d        = state_q;
    lit_d          = lit_q;
    mask_d         = mask_q;
    conflict_d     = conflict_q;
    conflict_lit_d = conflict_lit_q;
    cnt_d          = cnt_q;
    assigned_d     = assigned_q;
    value_d        = value_q;
    pop_en         = 1'b0;

    if (clr) begin
      // Restart wins over everything; counter and RR pointer survive.
      state_d        = ST_IDLE;
      mask_d         = '0;
      conflict_d     = 1'b0;
      conflict_lit_d = '0;
      assigned_d     = '0;
      value_d        = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            pop_en  = 1'b1;
            lit_d   = grant_lit;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (lit_var == '0) begin
            state_d = ST_IDLE;
          end else if (!assigned_q[lit_var]) begin
            assigned_d[lit_var] = 1'b1;
            value_d[lit_var]    = ~lit_neg;
            state_d             = ST_BCAST;
          end else if (value_q[lit_var] == ~lit_neg) begin
            // Already known with this polarity: nothing new to tell.
            state_d = ST_IDLE;
          end else begin
            conflict_d     = 1'b1;
            conflict_lit_d = lit_q;
            state_d        = ST_CONFLICT;
          end
        end
        ST_BCAST: begin
          // Current-cycle readies count toward completion directly.
          if (&(mask_q | bus.bc_ready)) begin
            cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            mask_d  = '0;
            state_d = ST_IDLE;
          end else begin
            mask_d = mask_q | bus.bc_ready;
          end
        end
        ST_CONFLICT: begin
          state_d = ST_CONFLICT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      lit_q          <= '0;
      mask_q         <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
      cnt_q          <= '0;
      assigned_q     <= '0;
      value_q        <= '0;
    end else begin
      state_q        <= state_d;
      lit_q          <= lit_d;
      mask_q         <= mask_d;
      conflict_q     <= conflict_d;
      conflict_lit_q <= conflict_lit_d;
      cnt_q          <= cnt_d;
      assigned_q     <= assigned_d;
      value_q        <= value_d;
    end
  end

  assign bus.ucq_pop  = pop_en ? grant : '0;
  assign bus.bc_valid = (state_q == ST_BCAST);
  assign bus.bc_lit   = lit_q;
  assign conflict     = conflict_q;
  assign conflict_lit = conflict_lit_q;
  assign busy         = (state_q != ST_IDLE);
  assign bc_cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_arbiter
// Description : Directed self-checking bench for uc_arbiter with a small
//               FIFO model standing in for the engine unit-clause queues.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uc_arbiter;
  import uc_pkg::*;

  localparam int NE = 4;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        conflict;
  logic [8:0]  conflict_lit;
  logic        busy;
  logic [15:0] bc_cnt;

  int pass_cnt;
  int chk_cnt;

  uc_arbiter_if #(.NUM_ENG(NE), .LIT_W(9)) sif ();

  uc_arbiter #(
    .NUM_ENG   (NE),
    .UC_LENGTH (512)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .bus          (sif),
    .conflict     (conflict),
    .conflict_lit (conflict_lit),
    .busy         (busy),
    .bc_cnt       (bc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue model: one small FIFO per engine.
  logic [8:0] fifo [NE][16];
  int         rp [NE];
  int         wp [NE];

  task automatic refresh();
    for (int i = 0; i < NE; i++) begin
      sif.ucq_empty[i] = (rp[i] == wp[i]);
      sif.ucq_head[i]  = (rp[i] == wp[i]) ? 9'h000 : fifo[i][rp[i] % 16];
    end
  endtask

  task automatic push(input int q, input logic [8:0] lit);
    fifo[q][wp[q] % 16] = lit;
    wp[q] = wp[q] + 1;
    refresh();
    #1;
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-cycle.
  task automatic step();
    logic [NE-1:0] pops;
    pops = sif.ucq_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < NE; i++) if (pops[i]) rp[i] = rp[i] + 1;
    refresh();
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (sif.bc_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #3;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (sif.bc_valid !== 1'b0) $display("FAIL reset_bc_valid got=%b exp=0", sif.bc_valid); else pass_cnt++;
    chk_cnt++; if (sif.bc_lit !== 9'h000) $display("FAIL reset_bc_lit got=%h exp=000", sif.bc_lit); else pass_cnt++;
    chk_cnt++; if (bc_cnt !== 16'd0) $display("FAIL reset_bc_cnt got=%0d exp=0", bc_cnt); else pass_cnt++;
    chk_cnt++; if (conflict !== 1'b0 || conflict_lit !== 9'h000)
      $display("FAIL reset_conflict got=%b/%h exp=0/000", conflict, conflict_lit); else pass_cnt++;
    chk_cnt++; if (sif.ucq_pop !== 4'b0000) $display("FAIL reset_pop got=%b exp=0000", sif.ucq_pop); else pass_cnt++;
    step();
    rst = 1'b1;
    #1;
    step();
    chk_cnt++; if (busy !== 1'b0 || sif.ucq_pop !== 4'b0000)
      $display("FAIL idle_empty got busy=%b pop=%b exp 0/0000", busy, sif.ucq_pop); else pass_cnt++;
  endtask

  task automatic test_single();
    sif.bc_ready = 4'h0;
    push(0, 9'h005);
    chk_cnt++; if (sif.ucq_pop !== 4'b0001) $display("FAIL single_pop got=%b exp=0001", sif.ucq_pop); else pass_cnt++;
    step();
    chk_cnt++; if (busy !== 1'b1 || sif.bc_valid !== 1'b0 || sif.ucq_pop !== 4'b0000)
      $display("FAIL single_check got busy=%b v=%b pop=%b exp 1/0/0000", busy, sif.bc_valid, sif.ucq_pop); else pass_cnt++;
    step();
    chk_cnt++; if (sif.bc_valid !== 1'b1 || sif.bc_lit !== 9'h005)
      $display("FAIL single_bcast got v=%b lit=%h exp 1/005", sif.bc_valid, sif.bc_lit); else pass_cnt++;
    sif.bc_ready = 4'hF;
    #1;
    step();
    chk_cnt++; if (sif.bc_valid !== 1'b0 || bc_cnt !== 16'd1 || busy !== 1'b0)
      $display("FAIL single_done got v=%b cnt=%0d busy=%b exp 0/1/0", sif.bc_valid, bc_cnt, busy); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [NE-1:0] exp_pop;
    int            order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    sif.bc_ready = 4'hF;
    push(0, 9'h011);
    push(0, 9'h015);
    push(1, 9'h012);
    push(2, 9'h013);
    push(3, 9'h014);
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 20 && sif.ucq_pop == '0; n++) step();
      exp_pop = NE'(1) << order[k];
      chk_cnt++; if (sif.ucq_pop !== exp_pop)
        $display("FAIL rr_grant%0d got=%b exp=%b", k, sif.ucq_pop, exp_pop); else pass_cnt++;
      step();
    end
    for (int n = 0; n < 20 && busy; n++) step();
    chk_cnt++; if (bc_cnt !== 16'd5 || busy !== 1'b0)
      $display("FAIL rr_count got cnt=%0d busy=%b exp 5/0", bc_cnt, busy); else pass_cnt++;
  endtask

  task automatic test_duplicate();
    bit any_valid;
    push(0, 9'h005);
    chk_cnt++; if (sif.ucq_pop !== 4'b0001) $display("FAIL dup_first_pop got=%b exp=0001", sif.ucq_pop); else pass_cnt++;
    step();
    step();
    chk_cnt++; if (sif.bc_valid !== 1'b1 || sif.bc_lit !== 9'h005)
      $display("FAIL dup_first_bcast got v=%b lit=%h exp 1/005", sif.bc_valid, sif.bc_lit); else pass_cnt++;
    step();
    push(2, 9'h005);
    chk_cnt++; if (sif.ucq_pop !== 4'b0100) $display("FAIL dup_pop got=%b exp=0100", sif.ucq_pop); else pass_cnt++;
    any_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      any_valid |= sif.bc_valid;
    end
    chk_cnt++; if (any_valid || bc_cnt !== 16'd6 || busy !== 1'b0)
      $display("FAIL dup_drop got v=%b cnt=%0d busy=%b exp 0/6/0", any_valid, bc_cnt, busy); else pass_cnt++;
    // Null literal with the negative bit set is still dropped.
    push(3, 9'h100);
    chk_cnt++; if (sif.ucq_pop !== 4'b1000) $display("FAIL null_pop got=%b exp=1000", sif.ucq_pop); else pass_cnt++;
    any_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      any_valid |= sif.bc_valid;
    end
    chk_cnt++; if (any_valid || bc_cnt !== 16'd6 || conflict !== 1'b0)
      $display("FAIL null_drop got v=%b cnt=%0d conf=%b exp 0/6/0", any_valid, bc_cnt, conflict); else pass_cnt++;
  endtask

  task automatic test_conflict();
    logic [NE-1:0] any_pop;
    bit            ok;
    push(0, 9'h105);
    chk_cnt++; if (sif.ucq_pop !== 4'b0001) $display("FAIL conf_pop got=%b exp=0001", sif.ucq_pop); else pass_cnt++;
    step();
    step();
    chk_cnt++; if (conflict !== 1'b1 || conflict_lit !== 9'h105 || sif.bc_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL conf_flag got c=%b lit=%h v=%b busy=%b exp 1/105/0/1", conflict, conflict_lit, sif.bc_valid, busy);
    else pass_cnt++;
    push(1, 9'h105);
    any_pop = '0;
    for (int n = 0; n < 4; n++) begin
      any_pop |= sif.ucq_pop;
      step();
    end
    chk_cnt++; if (any_pop !== 4'b0000 || conflict !== 1'b1)
      $display("FAIL conf_sticky got pops=%b c=%b exp 0000/1", any_pop, conflict); else pass_cnt++;
    clr = 1'b1;
    #1;
    chk_cnt++; if (sif.ucq_pop !== 4'b0000) $display("FAIL clr_pop got=%b exp=0000", sif.ucq_pop); else pass_cnt++;
    step();
    clr = 1'b0;
    #1;
    chk_cnt++; if (conflict !== 1'b0 || conflict_lit !== 9'h000 || busy !== 1'b0 || bc_cnt !== 16'd6)
      $display("FAIL clr_state got c=%b lit=%h busy=%b cnt=%0d exp 0/000/0/6", conflict, conflict_lit, busy, bc_cnt);
    else pass_cnt++;
    chk_cnt++; if (sif.ucq_pop !== 4'b0010) $display("FAIL clr_regrant got=%b exp=0010", sif.ucq_pop); else pass_cnt++;
    wait_valid(ok);
    chk_cnt++; if (!ok || sif.bc_lit !== 9'h105)
      $display("FAIL clr_rebcast got ok=%b lit=%h exp 1/105", ok, sif.bc_lit); else pass_cnt++;
    step();
    chk_cnt++; if (bc_cnt !== 16'd7 || conflict !== 1'b0)
      $display("FAIL clr_count got cnt=%0d c=%b exp 7/0", bc_cnt, conflict); else pass_cnt++;
  endtask

  task automatic test_stagger();
    bit         ok;
    logic [3:0] pat [4];
    bit         held;
    pat = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    sif.bc_ready = 4'h0;
    push(2, 9'h033);
    wait_valid(ok);
    chk_cnt++; if (!ok || sif.bc_lit !== 9'h033)
      $display("FAIL stag_start got ok=%b lit=%h exp 1/033", ok, sif.bc_lit); else pass_cnt++;
    held = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sif.bc_ready = pat[k];
      #1;
      held &= sif.bc_valid & (sif.bc_lit == 9'h033);
      step();
    end
    sif.bc_ready = 4'h0;
    #1;
    chk_cnt++; if (!held) $display("FAIL stag_hold got held=%b exp=1", held); else pass_cnt++;
    chk_cnt++; if (sif.bc_valid !== 1'b0 || bc_cnt !== 16'd8 || busy !== 1'b0)
      $display("FAIL stag_done got v=%b cnt=%0d busy=%b exp 0/8/0", sif.bc_valid, bc_cnt, busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    push(0, 9'h044);
    wait_valid(ok);
    chk_cnt++; if (!ok) $display("FAIL rmid_bcast got ok=%b exp=1", ok); else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++; if (sif.bc_valid !== 1'b0 || busy !== 1'b0 || bc_cnt !== 16'd0 || sif.bc_lit !== 9'h000 || sif.ucq_pop !== 4'b0000)
      $display("FAIL rmid_async got v=%b busy=%b cnt=%0d lit=%h pop=%b exp 0/0/0/000/0000",
               sif.bc_valid, busy, bc_cnt, sif.bc_lit, sif.ucq_pop);
    else pass_cnt++;
    rst = 1'b1;
    sif.bc_ready = 4'hF;
    #1;
    // Var 0x44 was assigned before reset; opposite polarity must now broadcast.
    push(0, uc_make_lit(1'b1, 8'h44));
    wait_valid(ok);
    chk_cnt++; if (!ok || sif.bc_lit !== 9'h144 || conflict !== 1'b0)
      $display("FAIL rmid_table got ok=%b lit=%h c=%b exp 1/144/0", ok, sif.bc_lit, conflict); else pass_cnt++;
    step();
    chk_cnt++; if (bc_cnt !== 16'd1) $display("FAIL rmid_count got=%0d exp=1", bc_cnt); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    rst = 1'b0;
    clr = 1'b0;
    sif.bc_ready = 4'h0;
    for (int i = 0; i < NE; i++) begin
      rp[i] = 0;
      wp[i] = 0;
    end
    refresh();
    test_reset();
    test_single();
    test_round_robin();
    test_duplicate();
    test_conflict();
    test_stagger();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
`default_nettype wire
